alu_ctrl_seq: RTL

Sequenced ALU control for the MIPS datapath: accepts decoded instructions over a valid/ready handshake, maps opcode (and, optionally, R-type funct) to a registered ALU operation code, and paces multi-cycle MUL/DIV operations with an internal latency counter. It sits between the decode stage and the ALU/MDU, replacing purely combinational opcode-to-ALU-op mapping. It holds off decode through `instr_ready_o` while a long operation is in flight.

---
 rtl/alu_ctrl_pkg.sv | 47 ++++
 rtl/alu_op_decode.sv | 88 ++++++++
 rtl/alu_ctrl_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the sequenced ALU control block.
// Opcode, R-type funct and ALU operation code maps, plus the FSM state type.
// Optional R-type funct decoding is selected with the ALU_CTRL_FUNCT_EN macro
// (see alu_op_decode).
package alu_ctrl_pkg;

    // Instruction opcodes
    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_SUB   = 1;
    localparam int unsigned OP_MUL   = 2;
    localparam int unsigned OP_DIV   = 3;
    localparam int unsigned OP_LW    = 4;
    localparam int unsigned OP_SW    = 5;
    localparam int unsigned OP_BR    = 6;
    localparam int unsigned OP_J     = 7;
    localparam int unsigned OP_RTYPE = 8;

    // R-type funct field values
    localparam int unsigned FN_ADD = 'h20;
    localparam int unsigned FN_SUB = 'h22;
    localparam int unsigned FN_AND = 'h24;
    localparam int unsigned FN_OR  = 'h25;
    localparam int unsigned FN_SLT = 'h2A;
    localparam int unsigned FN_MUL = 'h18;
    localparam int unsigned FN_DIV = 'h1A;

    // ALU operation codes; AND/OR/SLT are reachable only through R-type
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_MUL = 2;
    localparam int unsigned ALU_DIV = 3;
    localparam int unsigned ALU_LW  = 4;
    localparam int unsigned ALU_SW  = 5;
    localparam int unsigned ALU_BR  = 6;
    localparam int unsigned ALU_J   = 7;
    localparam int unsigned ALU_AND = 8;
    localparam int unsigned ALU_OR  = 9;
    localparam int unsigned ALU_SLT = 10;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct to ALU operation decoder.
// Produces the ALU code, a multi-cycle flag (MUL/DIV) and an illegal flag.
// An illegal encoding always yields ALU code 0.
// Macro ALU_CTRL_FUNCT_EN: when defined, opcode RTYPE is decoded through the
// funct field (adds AND/OR/SLT and R-type MUL/DIV); otherwise RTYPE is illegal
// and the funct input is ignored.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4
) (
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                multi,
    output logic                illegal
);

    logic [ALU_OP_W-1:0] rtype_op;
    logic                rtype_multi;
    logic                rtype_illegal;

`ifdef ALU_CTRL_FUNCT_EN
    // Decode the R-type funct field into an ALU code
    always_comb begin
        rtype_op      = '0;
        rtype_multi   = 1'b0;
        rtype_illegal = 1'b0;
        case (funct)
            FUNCT_W'(FN_ADD): rtype_op = ALU_OP_W'(ALU_ADD);
            FUNCT_W'(FN_SUB): rtype_op = ALU_OP_W'(ALU_SUB);
            FUNCT_W'(FN_AND): rtype_op = ALU_OP_W'(ALU_AND);
            FUNCT_W'(FN_OR):  rtype_op = ALU_OP_W'(ALU_OR);
            FUNCT_W'(FN_SLT): rtype_op = ALU_OP_W'(ALU_SLT);
            FUNCT_W'(FN_MUL): begin
                rtype_op    = ALU_OP_W'(ALU_MUL);
                rtype_multi = 1'b1;
            end
            FUNCT_W'(FN_DIV): begin
                rtype_op    = ALU_OP_W'(ALU_DIV);
                rtype_multi = 1'b1;
            end
            default: rtype_illegal = 1'b1;
        endcase
    end
`else
    // Without funct decoding the RTYPE opcode is simply unmapped
    logic unused_funct;
    assign unused_funct  = ^funct;
    assign rtype_op      = '0;
    assign rtype_multi   = 1'b0;
    assign rtype_illegal = 1'b1;
`endif

    // Map the primary opcode; anything outside the table is illegal
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        alu_op  = '0;
        multi   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_W'(OP_ADD): alu_op = ALU_OP_W'(ALU_ADD);
            OP_W'(OP_SUB): alu_op = ALU_OP_W'(ALU_SUB);
            OP_W'(OP_MUL): begin
                alu_op = ALU_OP_W'(ALU_MUL);
                multi  = 1'b1;
            end
            OP_W'(OP_DIV): begin
                alu_op = ALU_OP_W'(ALU_DIV);
                multi  = 1'b1;
            end
            OP_W'(OP_LW):    alu_op = ALU_OP_W'(ALU_LW);
            OP_W'(OP_SW):    alu_op = ALU_OP_W'(ALU_SW);
            OP_W'(OP_BR):    alu_op = ALU_OP_W'(ALU_BR);
            OP_W'(OP_J):     alu_op = ALU_OP_W'(ALU_J);
            OP_W'(OP_RTYPE): begin
                alu_op  = rtype_op;
                multi   = rtype_multi;
                illegal = rtype_illegal;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control: accepts decoded instructions over valid/ready,
// registers the ALU operation code and paces multi-cycle MUL/DIV with a
// down-counter, holding off decode while a long operation is in flight.
// Macro ALU_CTRL_FUNCT_EN enables R-type funct decoding (inside alu_op_decode).
// The counter is $clog2(DIV_LAT) bits wide, so MUL_LAT is assumed <= DIV_LAT.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FUNCT_W  = 6,
    parameter int ALU_OP_W = 4,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic [FUNCT_W-1:0]  instr_funct_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                alu_valid_o,
    output logic                alu_multi_o,
    output logic                alu_done_o,
    output logic                illegal_o
);

    localparam int CNT_W = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ill_q, ill_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;

    logic [ALU_OP_W-1:0] dec_op;
    logic                dec_multi;
    logic                dec_illegal;
    logic                transfer;

    alu_op_decode #(
        .OP_W     (OP_W),
        .FUNCT_W  (FUNCT_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .op      (instr_op_i),
        .funct   (instr_funct_i),
        .alu_op  (dec_op),
        .multi   (dec_multi),
        .illegal (dec_illegal)
    );

    // Ready depends only on registered state; masking with rst_i keeps ready
    // low during reset and also makes valid ignored while reset is held.
    assign instr_ready_o = ~rst_i & (state_q != ST_BUSY);
    assign transfer      = instr_valid_i & instr_ready_o;

    // Next-state, counter and operation-code selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ill_d    = ill_q;
        alu_op_d = alu_op_q;
        case (state_q)
            ST_IDLE, ST_EXEC: begin
                state_d = ST_IDLE;
                ill_d   = 1'b0;
                if (transfer) begin
                    alu_op_d = dec_illegal ? '0 : dec_op;
                    ill_d    = dec_illegal;
                    if (dec_multi && !dec_illegal) begin
                        state_d = ST_BUSY;
                        cnt_d   = (dec_op == ALU_OP_W'(ALU_MUL)) ? MUL_LOAD : DIV_LOAD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_BUSY: begin
                // Count 0 marks the final execute cycle; never wrap below it
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and operation registers with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ill_q    <= 1'b0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ill_q    <= ill_d;
            alu_op_q <= alu_op_d;
        end
    end

    // Execute-side outputs are decoded from registered state only
    assign alu_op_o    = alu_op_q;
    assign alu_multi_o = (state_q == ST_BUSY);
    assign alu_valid_o = (state_q == ST_BUSY) | ((state_q == ST_EXEC) & ~ill_q);
    assign alu_done_o  = ((state_q == ST_BUSY) & (cnt_q == '0)) |
                         ((state_q == ST_EXEC) & ~ill_q);
    assign illegal_o   = (state_q == ST_EXEC) & ill_q;

endmodule
